// File: rtl/packet_tx.sv
// Packet transmitter: buffers a length-framed payload, then emits header, payload words
// and an idle gap as a registered 32-bit word stream. All-zero words mark idle cycles.
module packet_tx #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_dest,
    input  logic [7:0]  req_src,
    input  logic [15:0] req_len,
    input  logic        pay_valid,
    output logic        pay_ready,
    input  logic [31:0] pay_data,
    output logic [31:0] out_word,
    output logic        busy,
    output logic        err_drop
);

    localparam int unsigned PTR_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHdr,
        StData,
        StGap
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_dest, w_dest_nxt;
    logic [7:0]         r_src, w_src_nxt;
    logic [15:0]        r_len, w_len_nxt;
    logic [PTR_W-1:0]   r_wptr, w_wptr_nxt;
    logic [PTR_W-1:0]   r_rptr, w_rptr_nxt;
    logic [3:0]         r_gap_cnt, w_gap_cnt_nxt;
    logic [31:0]        r_out_word, w_out_word_nxt;
    logic               r_err_drop, w_err_drop_nxt;
    logic               w_buf_we;
    logic               w_req_hs;
    logic               w_pay_hs;
    logic               w_req_ok;
    logic [31:0]        r_buf [DEPTH];

    // Ready is held low while reset is asserted, not just after the reset edge.
    assign req_ready = (r_state == StIdle) && !rst;
    assign pay_ready = (r_state == StLoad) && !rst;
    assign busy      = (r_state != StIdle);
    assign out_word  = r_out_word;
    assign err_drop  = r_err_drop;

    assign w_req_hs = req_valid && req_ready;
    assign w_pay_hs = pay_valid && pay_ready;
    assign w_req_ok = (req_len != 16'd0) && (req_len <= 16'(DEPTH)) &&
                      (req_dest >= 8'd1) && (req_dest <= 8'd4);

    always_comb begin
        w_state_nxt    = r_state;
        w_dest_nxt     = r_dest;
        w_src_nxt      = r_src;
        w_len_nxt      = r_len;
        w_wptr_nxt     = r_wptr;
        w_rptr_nxt     = r_rptr;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_out_word_nxt = 32'd0;
        w_err_drop_nxt = 1'b0;
        w_buf_we       = 1'b0;

        // out_word is registered from the next state so it lines up with r_state.
        unique case (r_state)
            StIdle: begin
                if (w_req_hs) begin
                    if (w_req_ok) begin
                        w_dest_nxt  = req_dest;
                        w_src_nxt   = req_src;
                        w_len_nxt   = req_len;
                        w_wptr_nxt  = '0;
                        w_rptr_nxt  = '0;
                        w_state_nxt = StLoad;
                    end else begin
                        w_err_drop_nxt = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (w_pay_hs) begin
                    w_buf_we   = 1'b1;
                    w_wptr_nxt = r_wptr + PTR_W'(1);
                    if (16'(r_wptr) + 16'd1 == r_len) begin
                        w_state_nxt    = StHdr;
                        w_out_word_nxt = {r_dest, r_len, r_src};
                    end
                end
            end
            StHdr: begin
                w_out_word_nxt = r_buf[r_rptr[IDX_W-1:0]];
                w_rptr_nxt     = r_rptr + PTR_W'(1);
                w_state_nxt    = StData;
            end
            StData: begin
                if (16'(r_rptr) == r_len) begin
                    w_gap_cnt_nxt = 4'd0;
                    w_state_nxt   = StGap;
                end else begin
                    w_out_word_nxt = r_buf[r_rptr[IDX_W-1:0]];
                    w_rptr_nxt     = r_rptr + PTR_W'(1);
                end
            end
            StGap: begin
                if (r_gap_cnt == 4'(GAP_CYCLES - 1)) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_dest     <= 8'd0;
            r_src      <= 8'd0;
            r_len      <= 16'd0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_gap_cnt  <= 4'd0;
            r_out_word <= 32'd0;
            r_err_drop <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dest     <= w_dest_nxt;
            r_src      <= w_src_nxt;
            r_len      <= w_len_nxt;
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_out_word <= w_out_word_nxt;
            r_err_drop <= w_err_drop_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[r_wptr[IDX_W-1:0]] <= pay_data;
        end
    end

endmodule

// File: tb/tb_packet_tx.sv
// Directed bench for packet_tx: drives on the falling edge, checks outputs there too.
module tb_packet_tx;

    localparam int unsigned DEPTH      = 16;
    localparam int unsigned GAP_CYCLES = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_dest;
    logic [7:0]  req_src;
    logic [15:0] req_len;
    logic        pay_valid;
    logic        pay_ready;
    logic [31:0] pay_data;
    logic [31:0] out_word;
    logic        busy;
    logic        err_drop;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] w [16];

    packet_tx #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dest  (req_dest),
        .req_src   (req_src),
        .req_len   (req_len),
        .pay_valid (pay_valid),
        .pay_ready (pay_ready),
        .pay_data  (pay_data),
        .out_word  (out_word),
        .busy      (busy),
        .err_drop  (err_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_req(input logic [7:0] d, input logic [7:0] s, input logic [15:0] l);
        int waited = 0;
        while (req_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_dest  = d;
        req_src   = s;
        req_len   = l;
        tick();
        req_valid = 1'b0;
        check("busy_after_req", 32'(busy), 32'd1);
    endtask

    // Ends on the cycle after the final payload handshake, where the header must be visible.
    task automatic do_load(input int len, input bit toggle, input logic [31:0] hdr);
        for (int k = 0; k < len; k++) begin
            pay_valid = 1'b1;
            pay_data  = w[k];
            check($sformatf("pay_ready_w%0d", k), 32'(pay_ready), 32'd1);
            tick();
            pay_valid = 1'b0;
            pay_data  = 32'hFFFF_FFFF;
            if (k < len - 1) begin
                check($sformatf("zero_in_load_w%0d", k), out_word, 32'd0);
                if (toggle) begin
                    repeat (2) tick();
                    check($sformatf("zero_in_stall_w%0d", k), out_word, 32'd0);
                end
            end
        end
        check("hdr_latency", out_word, hdr);
    endtask

    task automatic do_data(input int len);
        for (int k = 0; k < len; k++) begin
            tick();
            check($sformatf("data_w%0d", k), out_word, w[k]);
        end
    endtask

    task automatic do_tail();
        for (int g = 0; g < int'(GAP_CYCLES); g++) begin
            tick();
            check("gap_zero", out_word, 32'd0);
            check("gap_busy", 32'(busy), 32'd1);
        end
        tick();
        check("idle_not_busy", 32'(busy), 32'd0);
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("idle_zero", out_word, 32'd0);
    endtask

    task automatic bad_req(input logic [7:0] d, input logic [15:0] l);
        req_valid = 1'b1;
        req_dest  = d;
        req_src   = 8'h55;
        req_len   = l;
        tick();
        req_valid = 1'b0;
        check($sformatf("err_pulse_d%0d_l%0d", d, l), 32'(err_drop), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        check("err_out_zero", out_word, 32'd0);
        tick();
        check("err_pulse_end", 32'(err_drop), 32'd0);
        check("err_busy_after", 32'(busy), 32'd0);
        check("err_ready_after", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_dest  = 8'd0;
        req_src   = 8'd0;
        req_len   = 16'd0;
        pay_valid = 1'b0;
        pay_data  = 32'd0;
        repeat (3) tick();
        check("rst_out", out_word, 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_pay_ready", 32'(pay_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_drop), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Payload offered while idle must be ignored.
        pay_valid = 1'b1;
        pay_data  = 32'hDEAD_BEEF;
        check("idle_pay_ready", 32'(pay_ready), 32'd0);
        repeat (2) tick();
        pay_valid = 1'b0;

        // dest=3 len=5 src=1
        w[0] = 32'd32; w[1] = 32'd10; w[2] = 32'd7; w[3] = 32'd128; w[4] = 32'd200;
        do_req(8'd3, 8'd1, 16'd5);
        do_load(5, 1'b0, 32'h0300_0501);
        do_data(5);
        do_tail();

        // Back-to-back: dest=1 len=3 src=2
        w[0] = 32'd119; w[1] = 32'd78; w[2] = 32'd43;
        do_req(8'd1, 8'd2, 16'd3);
        do_load(3, 1'b0, 32'h0100_0302);
        do_data(3);
        do_tail();

        // Stalled payload: dest=4 len=4 src=9
        w[0] = 32'h1111_1111; w[1] = 32'h2222_2222; w[2] = 32'h3333_3333; w[3] = 32'h4444_4444;
        do_req(8'd4, 8'd9, 16'd4);
        do_load(4, 1'b1, 32'h0400_0409);
        do_data(4);
        do_tail();

        bad_req(8'd0, 16'd5);
        bad_req(8'd5, 16'd5);
        bad_req(8'd2, 16'd0);
        bad_req(8'd2, 16'd17);

        // Full buffer, includes a zero payload word.
        for (int k = 0; k < 16; k++) w[k] = 32'(k);
        do_req(8'd2, 8'd3, 16'd16);
        do_load(16, 1'b0, 32'h0200_1003);
        do_data(16);
        do_tail();

        // Reset while the third data word is on the output.
        w[0] = 32'hA0; w[1] = 32'hA1; w[2] = 32'hA2; w[3] = 32'hA3; w[4] = 32'hA4;
        do_req(8'd2, 8'd7, 16'd5);
        do_load(5, 1'b0, 32'h0200_0507);
        do_data(3);
        rst = 1'b1;
        tick();
        check("midrst_out", out_word, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("after_rst_ready", 32'(req_ready), 32'd1);
        check("after_rst_out", out_word, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("after_rst_zero%0d", k), out_word, 32'd0);
        end

        w[0] = 32'hCAFE_0001; w[1] = 32'hCAFE_0002;
        do_req(8'd1, 8'hAA, 16'd2);
        do_load(2, 1'b0, 32'h0100_02AA);
        do_data(2);
        do_tail();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/packet_tx.md
PACKET_TX -- requirements
Module: packet_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 16: payload buffer depth in words and maximum legal packet length.
REQ-002 SHALL have parameter GAP_CYCLES, default 1: minimum number of idle (all-zero) words between packets, range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic samples on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: a packet request is presented.
REQ-006 SHALL have port req_ready, output, 1 bit: a request can be accepted.
REQ-007 SHALL have port req_dest, input, 8 bits: destination port; legal values 1..4.
REQ-008 SHALL have port req_src, input, 8 bits: source port ID; passed through unchecked.
REQ-009 SHALL have port req_len, input, 16 bits: payload word count.
REQ-010 SHALL have port pay_valid, input, 1 bit: a payload word is presented.
REQ-011 SHALL have port pay_ready, output, 1 bit: a payload word can be accepted.
REQ-012 SHALL have port pay_data, input, 32 bits: payload word.
REQ-013 SHALL have port out_word, output, 32 bits: registered word stream into a switch input_N port.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port err_drop, output, 1 bit: one-cycle pulse when a request is rejected.

Function
REQ-016 SHALL implement states IDLE, LOAD, HDR, DATA and GAP.
REQ-017 A handshake SHALL occur only on a cycle where valid and ready are both 1.
REQ-018 req_ready SHALL be 1 only in IDLE; pay_ready SHALL be 1 only in LOAD.
REQ-019 IDLE, on request handshake: if req_len is 0, req_len > DEPTH, or req_dest is outside 1..4, stay in IDLE and pulse err_drop in the next cycle; otherwise latch dest/src/len and go to LOAD.
REQ-020 LOAD SHALL write each accepted payload word into the buffer in order; after the handshake of word len it goes to HDR; it waits indefinitely on pay_valid=0.
REQ-021 HDR SHALL drive out_word = {dest[7:0], len[15:0], src[7:0]} (bits 31:24, 23:8, 7:0) for exactly 1 cycle, then go to DATA.
REQ-022 DATA SHALL drive the buffered words in acceptance order on len consecutive cycles with no bubbles, then go to GAP.
REQ-023 GAP SHALL last exactly GAP_CYCLES cycles, then go to IDLE.
REQ-024 out_word SHALL be 32'd0 in every cycle outside HDR and DATA. The zero idle word is unambiguous because dest is never 0.
REQ-025 Latency: the header SHALL appear on out_word in the cycle after the final payload handshake.
REQ-026 Request-to-request spacing SHALL be at least 1 + len + 1 + GAP_CYCLES + 1 cycles.
REQ-027 A payload word whose value is 0 SHALL be transmitted unchanged; framing is length-based only.
REQ-028 pay_valid asserted outside LOAD SHALL be ignored; no word is consumed.
REQ-029 A req_len = DEPTH packet SHALL fill the buffer exactly with no overflow; the buffer read and write pointers SHALL reset to 0 at each packet start.

Reset
REQ-030 While rst=1, on each rising edge: state to IDLE, buffer pointers and counters to 0, out_word 32'd0, req_ready 0, pay_ready 0, busy 0, err_drop 0.
REQ-031 The first cycle after rst deasserts SHALL have req_ready = 1.
REQ-032 Reset asserted mid-packet (LOAD, HDR, DATA or GAP) SHALL abort the packet; no further payload words appear, and out_word is 0 from the cycle after the reset edge.

Verification
REQ-033 Request dest=3, len=5, src=1 with payload 32,10,7,128,200 -> out_word = 0x03000501, then 32, 10, 7, 128, 200 on consecutive cycles, then 0.
REQ-034 Request dest=1, len=3, src=2 with payload 119,78,43 sent back-to-back after REQ-033 -> 0x01000302, 119, 78, 43, with exactly GAP_CYCLES zeros minimum between the two packets.
REQ-035 pay_valid toggled 1,0,0,1,... during LOAD of a len=4 packet -> no output until all 4 words are accepted; then the header and 4 words appear contiguous.
REQ-036 Requests with dest=0, dest=5, len=0 and len=17 (DEPTH=16) -> each gives one err_drop pulse, busy stays 0, out_word stays 0.
REQ-037 len=16 with payload 0..15, including a zero word -> header 0x02001003 (dest=2, src=3) followed by all 16 words exactly.
REQ-038 rst=1 for 1 cycle during the third DATA word of a len=5 packet -> out_word 0 thereafter, req_ready=1 on the next cycle, and a following packet is transmitted correctly.
